// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter. Issues a one-hot HGRANT, tracks the
// address-phase owner on HMASTER/HMASTLOCK, and only re-arbitrates at burst
// boundaries or when a locked sequence has been released.
module ahb_bus_arbiter #(
  parameter int unsigned MASTERS_NUM = 4,
  parameter int unsigned MIDX_W      = $clog2(MASTERS_NUM)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [MASTERS_NUM-1:0] HBUSREQ,
  input  logic [MASTERS_NUM-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [MASTERS_NUM-1:0] HGRANT,
  output logic [MIDX_W-1:0]      HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr   = 3'b001;

  // The round-robin pointer always equals the granted index (both reset to 0
  // and both load the winner), so one register serves as both.
  logic [MIDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [MIDX_W-1:0] hmaster_q;
  logic              hmastlock_q;
  logic [4:0]        beat_cnt_q, beat_cnt_d;

  logic [4:0]        burst_len;
  logic              fixed_burst;
  logic              arb_ok;
  logic              win_found;
  logic [MIDX_W-1:0] win_idx;
  logic [MIDX_W:0]   cand_sum;
  logic [MIDX_W-1:0] cand_idx;

  // Decode burst length; INCR has no defined length and decodes to 0.
  always_comb begin
    unique case (HBURST)
      3'b000:         burst_len = 5'd1;
      3'b001:         burst_len = 5'd0;
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      default:        burst_len = 5'd16;
    endcase
    fixed_burst = (HBURST != BurstSingle) && (HBURST != BurstIncr);
  end

  // Beat counter: remaining beats after the current one.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (HREADY) begin
      if (HTRANS == TransNonseq) begin
        beat_cnt_d = (HBURST == BurstIncr) ? 5'd0 : burst_len - 5'd1;
      end else if ((HTRANS == TransSeq) && (beat_cnt_q != 5'd0)) begin
        beat_cnt_d = beat_cnt_q - 5'd1;
      end
    end
  end

  // Re-arbitration point: last beat of a transfer/burst, never during BUSY
  // or while the granted master holds HLOCK.
  always_comb begin
    arb_ok = HREADY && !HLOCK[grant_idx_q] && (HTRANS != TransBusy) &&
             ((HTRANS == TransIdle) ||
              ((HTRANS == TransNonseq) && (burst_len == 5'd1)) ||
              ((HTRANS == TransSeq) && (beat_cnt_q == 5'd1) && fixed_burst) ||
              ((HBURST == BurstIncr) && !HBUSREQ[grant_idx_q]));
  end

  // Round-robin search starting one past the current owner, wrapping; the
  // owner itself is visited last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = grant_idx_q;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= MASTERS_NUM; i++) begin
      cand_sum = {1'b0, grant_idx_q} + (MIDX_W + 1)'(i);
      if (cand_sum >= (MIDX_W + 1)'(MASTERS_NUM)) begin
        cand_sum = cand_sum - (MIDX_W + 1)'(MASTERS_NUM);
      end
      cand_idx = cand_sum[MIDX_W-1:0];
      if (!win_found && HBUSREQ[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    // No requester: park on the last owner.
    grant_idx_d = (arb_ok && win_found) ? win_idx : grant_idx_q;
  end

  // Grant, owner and beat-counter state; owner lags grant by one ready edge.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_idx_q <= '0;
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      grant_idx_q <= grant_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      if (HREADY) begin
        hmaster_q   <= grant_idx_q;
        hmastlock_q <= HLOCK[grant_idx_q];
      end
    end
  end

  // One-hot grant decoded from the registered index.
  always_comb begin
    HGRANT              = '0;
    HGRANT[grant_idx_q] = 1'b1;
  end

  assign HMASTER   = hmaster_q;
  assign HMASTLOCK = hmastlock_q;

  grant_onehot_a: assert property (@(posedge HCLK) disable iff (!HRESETn) $onehot(HGRANT));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (4 masters).
module tb_ahb_bus_arbiter;

  logic       HCLK;
  logic       HRESETn;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int checks;
  int passed;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  ahb_bus_arbiter #(
    .MASTERS_NUM(4)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HBURST   (HBURST),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Advance past the next rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    HBUSREQ = 4'b1111;
    HLOCK   = 4'b0000;
    HTRANS  = IDLE;
    HBURST  = 3'b000;
    HREADY  = 1'b1;
    repeat (3) tick();
    checks++;
    if (HGRANT !== 4'b0001) $display("FAIL reset_grant: got %b expected 0001", HGRANT);
    else passed++;
    checks++;
    if (HMASTER !== 2'd0) $display("FAIL reset_hmaster: got %0d expected 0", HMASTER);
    else passed++;
    checks++;
    if (HMASTLOCK !== 1'b0) $display("FAIL reset_hmastlock: got %b expected 0", HMASTLOCK);
    else passed++;
    HRESETn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    logic [1:0] exp_m [4];
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_m = '{2'd1, 2'd2, 2'd3, 2'd0};
    HBUSREQ = 4'b1111;
    HTRANS  = NONSEQ;
    HBURST  = 3'b000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e <= 4) begin
        checks++;
        if (HGRANT !== exp_g[e-1])
          $display("FAIL rr_grant_%0d: got %b expected %b", e, HGRANT, exp_g[e-1]);
        else passed++;
      end
      if (e >= 2) begin
        checks++;
        if (HMASTER !== exp_m[e-2])
          $display("FAIL rr_hmaster_%0d: got %0d expected %0d", e, HMASTER, exp_m[e-2]);
        else passed++;
      end
    end
  endtask

  task automatic test_fixed_burst();
    logic [1:0] tr [6];
    logic       rd [6];
    logic [3:0] rq [6];
    logic [3:0] eg [6];
    // NONSEQ, SEQ1, SEQ2 stalled, BUSY, SEQ2, SEQ3 (last beat)
    tr = '{NONSEQ, SEQ, SEQ, BUSY, SEQ, SEQ};
    rd = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rq = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    // Master 1 holds the grant; one idle edge makes it the address owner.
    HBUSREQ = 4'b0010;
    HTRANS  = IDLE;
    tick();
    checks++;
    if (HMASTER !== 2'd1) $display("FAIL burst_owner: got %0d expected 1", HMASTER);
    else passed++;
    HBURST = 3'b011;  // INCR4
    for (int b = 0; b < 6; b++) begin
      HTRANS  = tr[b];
      HREADY  = rd[b];
      HBUSREQ = rq[b];
      tick();
      checks++;
      if (HGRANT !== eg[b])
        $display("FAIL burst_grant_%0d: got %b expected %b", b, HGRANT, eg[b]);
      else passed++;
    end
    checks++;
    if (HMASTER !== 2'd1) $display("FAIL burst_last_owner: got %0d expected 1", HMASTER);
    else passed++;
  endtask

  task automatic test_undefined_incr();
    HTRANS  = IDLE;
    HBURST  = 3'b000;
    HREADY  = 1'b1;
    HBUSREQ = 4'b1000;
    tick();
    checks++;
    if (HGRANT !== 4'b1000) $display("FAIL incr_setup_grant: got %b expected 1000", HGRANT);
    else passed++;
    tick();
    checks++;
    if (HMASTER !== 2'd3) $display("FAIL incr_setup_owner: got %0d expected 3", HMASTER);
    else passed++;
    HBURST  = 3'b001;
    HBUSREQ = 4'b1001;
    for (int b = 0; b < 6; b++) begin
      HTRANS = (b == 0) ? NONSEQ : SEQ;
      tick();
      checks++;
      if (HGRANT !== 4'b1000)
        $display("FAIL incr_hold_%0d: got %b expected 1000", b, HGRANT);
      else passed++;
    end
    // Drop the request during a wait state: grant must not move yet.
    HBUSREQ = 4'b0001;
    HTRANS  = SEQ;
    HREADY  = 1'b0;
    tick();
    checks++;
    if (HGRANT !== 4'b1000) $display("FAIL incr_drop_wait: got %b expected 1000", HGRANT);
    else passed++;
    HREADY = 1'b1;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) $display("FAIL incr_release: got %b expected 0001", HGRANT);
    else passed++;
  endtask

  task automatic test_lock();
    HTRANS  = IDLE;
    HBURST  = 3'b000;
    HBUSREQ = 4'b0100;
    HLOCK   = 4'b0000;
    tick();
    checks++;
    if (HGRANT !== 4'b0100) $display("FAIL lock_setup: got %b expected 0100", HGRANT);
    else passed++;
    HLOCK   = 4'b0100;
    HBUSREQ = 4'b1111;
    HTRANS  = NONSEQ;
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++;
      if (HGRANT !== 4'b0100)
        $display("FAIL lock_grant_%0d: got %b expected 0100", t, HGRANT);
      else passed++;
      checks++;
      if (HMASTER !== 2'd2)
        $display("FAIL lock_owner_%0d: got %0d expected 2", t, HMASTER);
      else passed++;
      checks++;
      if (HMASTLOCK !== 1'b1)
        $display("FAIL lock_mastlock_%0d: got %b expected 1", t, HMASTLOCK);
      else passed++;
    end
    HLOCK = 4'b0000;
    tick();
    checks++;
    if (HGRANT !== 4'b1000) $display("FAIL lock_release: got %b expected 1000", HGRANT);
    else passed++;
    checks++;
    if (HMASTLOCK !== 1'b0) $display("FAIL lock_unlocked: got %b expected 0", HMASTLOCK);
    else passed++;
  endtask

  task automatic test_park_idle();
    HBUSREQ = 4'b0000;
    HTRANS  = IDLE;
    for (int t = 0; t < 2; t++) begin
      tick();
      checks++;
      if (HGRANT !== 4'b1000)
        $display("FAIL park_hold_%0d: got %b expected 1000", t, HGRANT);
      else passed++;
    end
    HBUSREQ = 4'b0001;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) $display("FAIL park_pulse: got %b expected 0001", HGRANT);
    else passed++;
    HBUSREQ = 4'b0000;
    tick();
    checks++;
    if (HGRANT !== 4'b0001) $display("FAIL park_after_pulse: got %b expected 0001", HGRANT);
    else passed++;
  endtask

  task automatic test_async_reset();
    HBUSREQ = 4'b0100;
    HTRANS  = IDLE;
    tick();
    HLOCK = 4'b0100;
    tick();
    checks++;
    if (HMASTLOCK !== 1'b1) $display("FAIL areset_pre_lock: got %b expected 1", HMASTLOCK);
    else passed++;
    checks++;
    if (HGRANT !== 4'b0100) $display("FAIL areset_pre_grant: got %b expected 0100", HGRANT);
    else passed++;
    // Assert reset between edges; outputs must clear before the next edge.
    #2;
    HRESETn = 1'b0;
    #1;
    checks++;
    if (HGRANT !== 4'b0001) $display("FAIL areset_grant: got %b expected 0001", HGRANT);
    else passed++;
    checks++;
    if (HMASTER !== 2'd0) $display("FAIL areset_hmaster: got %0d expected 0", HMASTER);
    else passed++;
    checks++;
    if (HMASTLOCK !== 1'b0) $display("FAIL areset_hmastlock: got %b expected 0", HMASTLOCK);
    else passed++;
    HLOCK   = 4'b0000;
    HBUSREQ = 4'b0000;
    tick();
    HRESETn = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_undefined_incr();
    test_lock();
    test_park_idle();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
